// File: rtl/retire_writeback.sv
// Retire/writeback stage: commits register writes from up to RETIRE_W slots per cycle
// and queues stores in an in-order buffer that drains one entry per cycle into memory.
module retire_writeback #(
  parameter int RETIRE_W  = 2,
  parameter int NUM_PREGS = 64,
  parameter int MEM_DEPTH = 64,
  parameter int DATA_W    = 32,
  parameter int SB_DEPTH  = 8,
  localparam int PREG_AW  = $clog2(NUM_PREGS),
  localparam int MEM_AW   = $clog2(MEM_DEPTH),
  localparam int SB_AW    = $clog2(SB_DEPTH),
  localparam int CNT_W    = SB_AW + 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [RETIRE_W-1:0]         retire_valid,
  input  logic [7*RETIRE_W-1:0]       retire_opcode,
  input  logic [PREG_AW*RETIRE_W-1:0] retire_curr_d_reg,
  input  logic [PREG_AW*RETIRE_W-1:0] retire_old_d_reg,
  input  logic [DATA_W*RETIRE_W-1:0]  retire_rd_value,
  input  logic [DATA_W*RETIRE_W-1:0]  retire_rs2_value,
  output logic                        retire_ready,
  output logic [NUM_PREGS-1:0]        reg_ready_o,
  output logic [NUM_PREGS-1:0]        free_regs,
  output logic [DATA_W-1:0]           register_file [NUM_PREGS],
  output logic [DATA_W-1:0]           memory [MEM_DEPTH],
  output logic [CNT_W-1:0]            sb_count,
  input  logic [MEM_AW-1:0]           dbg_addr,
  output logic [DATA_W-1:0]           dbg_data
);

  localparam logic [6:0] OP_STORE = 7'b0100011;

  logic [MEM_AW-1:0] r_sb_addr [SB_DEPTH];
  logic [DATA_W-1:0] r_sb_data [SB_DEPTH];
  logic [SB_AW-1:0]  r_sb_rd;
  logic [SB_AW-1:0]  r_sb_wr;

  logic [CNT_W-1:0]     w_free_slots;
  logic [RETIRE_W-1:0]  w_push;
  logic [RETIRE_W-1:0]  w_wr;
  logic [SB_AW-1:0]     w_push_idx [RETIRE_W];
  logic [CNT_W-1:0]     w_push_cnt;
  logic [NUM_PREGS-1:0] w_ready_mask;
  logic [NUM_PREGS-1:0] w_free_mask;
  logic                 w_pop;
  logic [SB_AW-1:0]     w_age_idx;

  // Space for a full group is required, so a group is never partially accepted.
  assign w_free_slots = CNT_W'(SB_DEPTH) - sb_count;
  assign retire_ready = (w_free_slots >= CNT_W'(RETIRE_W));
  assign w_pop        = (sb_count != '0);

  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    w_push       = '0;
    w_wr         = '0;
    w_push_cnt   = '0;
    w_ready_mask = '0;
    w_free_mask  = '0;
    for (int k = 0; k < RETIRE_W; k++) begin
      w_push_idx[k] = r_sb_wr + w_push_cnt[SB_AW-1:0];
      if (retire_ready && retire_valid[k]) begin
        if (retire_opcode[k*7 +: 7] == OP_STORE) begin
          w_push[k]  = 1'b1;
          w_push_cnt = w_push_cnt + CNT_W'(1);
        end else begin
          w_wr[k] = 1'b1;
          w_ready_mask[retire_curr_d_reg[k*PREG_AW +: PREG_AW]] = 1'b1;
          w_free_mask[retire_old_d_reg[k*PREG_AW +: PREG_AW]]   = 1'b1;
        end
      end
    end
  end

  // Walk the buffer oldest to youngest so the youngest matching store overrides.
  always_comb begin
    dbg_data  = memory[dbg_addr];
    w_age_idx = r_sb_rd;
    for (int i = 0; i < SB_DEPTH; i++) begin
      w_age_idx = r_sb_rd + SB_AW'(i);
      if ((CNT_W'(i) < sb_count) && (r_sb_addr[w_age_idx] == dbg_addr))
        dbg_data = r_sb_data[w_age_idx];
    end
  end

  // NOTE: all state here uses non-blocking assignments so every read sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the register file and memory are flop arrays that must read as zero after reset,
      // so they are cleared explicitly; a RAM macro could not be used for them.
      for (int p = 0; p < NUM_PREGS; p++) register_file[p] <= '0;
      for (int m = 0; m < MEM_DEPTH; m++) memory[m] <= '0;
      for (int s = 0; s < SB_DEPTH; s++) begin
        r_sb_addr[s] <= '0;
        r_sb_data[s] <= '0;
      end
      r_sb_rd     <= '0;
      r_sb_wr     <= '0;
      sb_count    <= '0;
      reg_ready_o <= '0;
      free_regs   <= '0;
    end else begin
      reg_ready_o <= w_ready_mask;
      free_regs   <= w_free_mask;
      // Ascending slot order lets the youngest slot win a shared destination.
      for (int k = 0; k < RETIRE_W; k++) begin
        if (w_wr[k])
          register_file[retire_curr_d_reg[k*PREG_AW +: PREG_AW]] <= retire_rd_value[k*DATA_W +: DATA_W];
        if (w_push[k]) begin
          r_sb_addr[w_push_idx[k]] <= retire_rd_value[k*DATA_W +: MEM_AW];
          r_sb_data[w_push_idx[k]] <= retire_rs2_value[k*DATA_W +: DATA_W];
        end
      end
      if (w_pop) begin
        memory[r_sb_addr[r_sb_rd]] <= r_sb_data[r_sb_rd];
        r_sb_rd <= r_sb_rd + SB_AW'(1);
      end
      r_sb_wr  <= r_sb_wr + w_push_cnt[SB_AW-1:0];
      sb_count <= sb_count + w_push_cnt - CNT_W'(w_pop);
    end
  end

endmodule

// File: tb/tb_retire_writeback.sv
// Scoreboarded bench for retire_writeback: a queue-based reference model predicts the
// post-edge state each cycle; a monitor compares it against the DUT after every rising edge.
module tb_retire_writeback;

  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        retire_valid;
  logic [13:0]       retire_opcode;
  logic [11:0]       retire_curr_d_reg, retire_old_d_reg;
  logic [63:0]       retire_rd_value, retire_rs2_value;
  logic              retire_ready;
  logic [63:0]       reg_ready_o, free_regs;
  logic [31:0]       register_file [64];
  logic [31:0]       memory [64];
  logic [3:0]        sb_count;
  logic [5:0]        dbg_addr;
  logic [31:0]       dbg_data;

  retire_writeback dut (
    .clk(clk), .reset(reset),
    .retire_valid(retire_valid), .retire_opcode(retire_opcode),
    .retire_curr_d_reg(retire_curr_d_reg), .retire_old_d_reg(retire_old_d_reg),
    .retire_rd_value(retire_rd_value), .retire_rs2_value(retire_rs2_value),
    .retire_ready(retire_ready), .reg_ready_o(reg_ready_o), .free_regs(free_regs),
    .register_file(register_file), .memory(memory), .sb_count(sb_count),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [5:0] a; logic [31:0] d; } st_t;
  typedef struct packed {
    logic              rdy;
    logic [3:0]        cnt;
    logic [63:0]       rmask;
    logic [63:0]       fmask;
    logic [31:0]       dbg;
    logic [63:0][31:0] rf;
    logic [63:0][31:0] mem;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference state: whole arrays plus an ordered list of pending stores.
  logic [63:0][31:0] m_rf, m_mem;
  st_t               sbq[$];

  // Stimulus for the next cycle
  logic        s_rst;
  logic [1:0]  s_v;
  logic [6:0]  s_op  [2];
  logic [5:0]  s_cur [2];
  logic [5:0]  s_old [2];
  logic [31:0] s_rd  [2];
  logic [31:0] s_rs2 [2];
  logic [5:0]  s_dbg;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_stim();
    s_rst = 1'b0;
    s_v   = 2'b00;
    for (int k = 0; k < 2; k++) begin
      s_op[k] = OP_ALU; s_cur[k] = '0; s_old[k] = '0; s_rd[k] = '0; s_rs2[k] = '0;
    end
  endtask

  // Drive one cycle of stimulus and predict the state after the coming rising edge.
  task automatic step();
    exp_t e;
    st_t  st;
    logic rdy;
    @(negedge clk);
    reset             = s_rst;
    retire_valid      = s_v;
    retire_opcode     = {s_op[1], s_op[0]};
    retire_curr_d_reg = {s_cur[1], s_cur[0]};
    retire_old_d_reg  = {s_old[1], s_old[0]};
    retire_rd_value   = {s_rd[1], s_rd[0]};
    retire_rs2_value  = {s_rs2[1], s_rs2[0]};
    dbg_addr          = s_dbg;
    e.rmask = '0;
    e.fmask = '0;
    if (s_rst) begin
      m_rf  = '0;
      m_mem = '0;
      sbq.delete();
    end else begin
      rdy = (8 - sbq.size()) >= 2;
      if (sbq.size() > 0) begin
        st = sbq.pop_front();
        m_mem[st.a] = st.d;
      end
      if (rdy) begin
        for (int k = 0; k < 2; k++) begin
          if (s_v[k]) begin
            if (s_op[k] == OP_STORE) begin
              st.a = s_rd[k][5:0];
              st.d = s_rs2[k];
              sbq.push_back(st);
            end else begin
              m_rf[s_cur[k]]    = s_rd[k];
              e.rmask[s_cur[k]] = 1'b1;
              e.fmask[s_old[k]] = 1'b1;
            end
          end
        end
      end
    end
    e.rdy = (8 - sbq.size()) >= 2;
    e.cnt = 4'(sbq.size());
    e.dbg = m_mem[s_dbg];
    for (int i = 0; i < sbq.size(); i++)
      if (sbq[i].a == s_dbg) e.dbg = sbq[i].d;
    e.rf  = m_rf;
    e.mem = m_mem;
    exp_q.push_back(e);
  endtask

  // Monitor: one expectation per cycle, compared just after the rising edge.
  initial begin
    exp_t e;
    int   bi;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("retire_ready", 64'(retire_ready), 64'(e.rdy));
        check("sb_count", 64'(sb_count), 64'(e.cnt));
        check("reg_ready_o", reg_ready_o, e.rmask);
        check("free_regs", free_regs, e.fmask);
        check("dbg_data", 64'(dbg_data), 64'(e.dbg));
        bi = 0;
        for (int i = 0; i < 64; i++)
          if (register_file[i] !== e.rf[i]) begin bi = i; break; end
        check($sformatf("register_file[%0d]", bi), 64'(register_file[bi]), 64'(e.rf[bi]));
        bi = 0;
        for (int i = 0; i < 64; i++)
          if (memory[i] !== e.mem[i]) begin bi = i; break; end
        check($sformatf("memory[%0d]", bi), 64'(memory[bi]), 64'(e.mem[bi]));
      end
    end
  end

  initial begin
    reset = 1'b1; retire_valid = '0; retire_opcode = '0;
    retire_curr_d_reg = '0; retire_old_d_reg = '0;
    retire_rd_value = '0; retire_rs2_value = '0; dbg_addr = '0;
    s_dbg = '0;
    idle_stim();

    s_rst = 1'b1;
    repeat (2) step();
    idle_stim();
    step();

    // Single register write, then an idle cycle to see the pulses clear.
    s_v = 2'b01; s_op[0] = OP_ALU; s_cur[0] = 6'd5; s_old[0] = 6'd12; s_rd[0] = 32'hDEAD;
    step();
    idle_stim();
    step();

    // Two slots targeting the same destination: the younger value must stick.
    s_v = 2'b11;
    s_op[0] = OP_ALU; s_cur[0] = 6'd7; s_old[0] = 6'd20; s_rd[0] = 32'd1;
    s_op[1] = OP_ALU; s_cur[1] = 6'd7; s_old[1] = 6'd21; s_rd[1] = 32'd2;
    step();
    idle_stim();
    step();

    // Sustained dual stores fill the buffer until retire_ready drops, then drain.
    for (int c = 0; c < 12; c++) begin
      s_v = 2'b11;
      s_op[0] = OP_STORE; s_rd[0] = 32'd3; s_rs2[0] = 32'h300 + 32'(c);
      s_op[1] = OP_STORE; s_rd[1] = 32'd4; s_rs2[1] = 32'h400 + 32'(c);
      s_dbg = 6'd4;
      step();
    end
    idle_stim();
    repeat (10) step();

    // Forwarding from the buffer before the drain reaches memory.
    s_v = 2'b01; s_op[0] = OP_STORE; s_rd[0] = 32'd9; s_rs2[0] = 32'h55; s_dbg = 6'd9;
    step();
    idle_stim();
    step();
    step();

    // Upper address bits are ignored.
    s_v = 2'b01; s_op[0] = OP_STORE; s_rd[0] = 32'h1_0003; s_rs2[0] = 32'hABCD; s_dbg = 6'd3;
    step();
    idle_stim();
    repeat (2) step();

    // Reset while three stores are pending.
    s_v = 2'b11;
    s_op[0] = OP_STORE; s_rd[0] = 32'd10; s_rs2[0] = 32'hA1;
    s_op[1] = OP_STORE; s_rd[1] = 32'd11; s_rs2[1] = 32'hB2;
    s_dbg = 6'd10;
    step();
    step();
    idle_stim();
    s_rst = 1'b1;
    step();
    idle_stim();
    repeat (3) step();

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      s_rst = ($urandom_range(0, 59) == 0);
      s_v   = 2'($urandom);
      for (int k = 0; k < 2; k++) begin
        s_op[k]  = ($urandom_range(0, 9) < 6) ? OP_STORE : 7'($urandom);
        s_cur[k] = 6'($urandom);
        s_old[k] = 6'($urandom);
        s_rd[k]  = $urandom;
        if (s_op[k] == OP_STORE) s_rd[k][5:0] = 6'($urandom_range(0, 15));
        s_rs2[k] = $urandom;
      end
      s_dbg = 6'($urandom_range(0, 15));
      step();
    end
    idle_stim();
    repeat (12) step();

    repeat (2) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
